alu_arb: RTL and testbench

Round-robin arbiter and issue controller that shares the pipeline's single combinational `alu` between `NREQ` requesters, for example the execute stage and a secondary address/compare unit. Each requester uses a valid/ready handshake. The block registers one ALU result per cycle into an output slot with its own valid/ready handshake, and tags each result with the winning requester index. It sits between the requester stages and their consumers and gives one-cycle issue-to-result latency at full throughput.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/alu.sv | 25 ++
 rtl/alu_arb.sv | 127 ++++++++++++
 tb/tb_alu_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcodes, slot state type and opcode legality helper for the alu_arb block.
package alu_arb_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_st_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Pipeline's combinational ALU; SLT is a signed compare, unused codes yield zero.
module alu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (alucontrol)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a registered result slot.
// Optional illegal-opcode check enabled by defining ALU_ARB_ILLEGAL_CHK_EN.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy
);

  slot_st_t         state_reg;
  logic [IDW-1:0]   last_ptr_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic             rsp_zero_reg;
  logic             rsp_err_reg;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             found;
  logic             can_accept;
  logic             accept;

  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];
  logic [2:0]       op_arr [NREQ];

  logic [WIDTH-1:0] sel_a, sel_b, alu_y, cap_result;
  logic [2:0]       sel_op;
  logic             cap_err;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      assign op_arr[gi] = req_op[gi*3 +: 3];
    end
  endgenerate

  // Circular priority scan starting just past the last accepted requester.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_ptr_reg) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
      end
    end
  end

  assign can_accept = (state_reg == EMPTY) || rsp_ready;
  assign req_ready  = grant & {NREQ{can_accept & ~reset}};
  assign accept     = |(req_valid & req_ready);

  assign sel_a  = a_arr[gidx];
  assign sel_b  = b_arr[gidx];
  assign sel_op = op_arr[gidx];

  alu #(.WIDTH(WIDTH)) u_alu (
    .a          (sel_a),
    .b          (sel_b),
    .alucontrol (sel_op),
    .y          (alu_y)
  );

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign cap_err    = ~op_is_legal(sel_op);
  assign cap_result = cap_err ? '0 : alu_y;
`else
  assign cap_err    = 1'b0;
  assign cap_result = alu_y;
`endif

  // A drain and a new load on the same edge simply reload the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= EMPTY;
      last_ptr_reg   <= IDW'(NREQ - 1);
      rsp_result_reg <= '0;
      rsp_id_reg     <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_reg <= FULL;
        FULL:  if (rsp_ready && !accept) state_reg <= EMPTY;
        default: state_reg <= EMPTY;
      endcase
      if (accept) begin
        last_ptr_reg   <= gidx;
        rsp_result_reg <= cap_result;
        rsp_id_reg     <= gidx;
        rsp_zero_reg   <= (cap_result == '0);
        rsp_err_reg    <= cap_err;
      end
    end
  end

  assign rsp_valid  = (state_reg == FULL);
  assign busy       = rsp_valid;
  assign rsp_result = rsp_result_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed vector table, reset/illegal-op sequences, then random traffic vs a queue model.
module tb_alu_arb;
  import alu_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  rsp_valid, rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_zero, rsp_err, busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] a0, b0;
    logic [2:0]  op0;
    logic [31:0] a1, b1;
    logic [2:0]  op1;
    logic        rdy;
    logic [1:0]  e_rdy;
    logic        e_v;
    logic [31:0] e_res;
    logic        e_id;
    logic        e_z;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        id;
    logic        z;
  } exp_t;

  function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] a0, b0, input logic [2:0] op0,
                              input logic [31:0] a1, b1, input logic [2:0] op1, input logic rdy,
                              input logic [1:0] e_rdy, input logic e_v, input logic [31:0] e_res,
                              input logic e_id, input logic e_z);
    vec_t v;
    v.vld = vld; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.a1 = a1; v.b1 = b1; v.op1 = op1; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_res = e_res; v.e_id = e_id; v.e_z = e_z;
    return v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [31:0] a0, b0, input logic [2:0] op0,
                       input logic [31:0] a1, b1, input logic [2:0] op1, input logic rdy);
    req_valid = vld;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_op    = {op1, op0};
    rsp_ready = rdy;
  endtask

  vec_t tbl [15];
  exp_t q [$];

  initial begin
    tbl[0]  = mk(2'b01, 32'd100, 32'd23, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 1'b1, 2'b01, 1'b1, 32'd123, 1'b0, 1'b0);
    tbl[1]  = mk(2'b10, 32'd0, 32'd0, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 1'b1, 2'b10, 1'b1, 32'd2, 1'b1, 1'b0);
    tbl[2]  = mk(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_AND, 32'h12345678, 32'h87654321, ALU_OR, 1'b1, 2'b01, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[3]  = mk(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_AND, 32'h12345678, 32'h87654321, ALU_OR, 1'b1, 2'b10, 1'b1, 32'h97755779, 1'b1, 1'b0);
    tbl[4]  = mk(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_AND, 32'h12345678, 32'h87654321, ALU_OR, 1'b1, 2'b01, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[5]  = mk(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_AND, 32'h12345678, 32'h87654321, ALU_OR, 1'b1, 2'b10, 1'b1, 32'h97755779, 1'b1, 1'b0);
    tbl[6]  = mk(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_AND, 32'h12345678, 32'h87654321, ALU_OR, 1'b0, 2'b00, 1'b1, 32'h97755779, 1'b1, 1'b0);
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = mk(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, ALU_AND, 32'h12345678, 32'h87654321, ALU_OR, 1'b1, 2'b01, 1'b1, 32'h0, 1'b0, 1'b1);
    tbl[10] = mk(2'b01, 32'd50, 32'd75, ALU_SUB, 32'd0, 32'd0, ALU_ADD, 1'b1, 2'b01, 1'b1, 32'hFFFFFFE7, 1'b0, 1'b0);
    tbl[11] = mk(2'b10, 32'd0, 32'd0, ALU_ADD, 32'd5, 32'd10, ALU_SLT, 1'b1, 2'b10, 1'b1, 32'd1, 1'b1, 1'b0);
    tbl[12] = mk(2'b01, 32'd20, 32'd10, ALU_SLT, 32'd0, 32'd0, ALU_ADD, 1'b1, 2'b01, 1'b1, 32'd0, 1'b0, 1'b1);
    tbl[13] = mk(2'b00, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0);
    tbl[14] = mk(2'b10, 32'd0, 32'd0, ALU_ADD, 32'd7, 32'd8, ALU_ADD, 1'b0, 2'b10, 1'b1, 32'd15, 1'b1, 1'b0);

    // Reset: requests present but nothing may be accepted.
    reset = 1'b1;
    drive(2'b11, 32'd1, 32'd2, ALU_ADD, 32'd3, 32'd4, ALU_ADD, 1'b1);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_zero", rsp_zero, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].a0, tbl[i].b0, tbl[i].op0, tbl[i].a1, tbl[i].b1, tbl[i].op1, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_v);
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_rsp_result", i), rsp_result, tbl[i].e_res);
        chk($sformatf("tbl%0d_rsp_id", i), rsp_id, tbl[i].e_id);
        chk($sformatf("tbl%0d_rsp_zero", i), rsp_zero, tbl[i].e_z);
      end
      $display("vector %0d: req_ready=%b rsp_valid=%b result=%h id=%0d zero=%b",
               i, req_ready, rsp_valid, rsp_result, rsp_id, rsp_zero);
    end

    // Illegal opcode 011 from req0 while the slot drains.
    drive(2'b01, 32'hFFFFFFFF, 32'd0, 3'b011, 32'd0, 32'd0, ALU_ADD, 1'b1);
    @(negedge clk);
    chk("illegal_req_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    chk("illegal_rsp_valid", rsp_valid, 1'b1);
    chk("illegal_rsp_id", rsp_id, 1'b0);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    chk("illegal_rsp_err", rsp_err, 1'b1);
    chk("illegal_rsp_result", rsp_result, 32'd0);
    chk("illegal_rsp_zero", rsp_zero, 1'b1);
`else
    chk("illegal_rsp_err", rsp_err, 1'b0);
`endif
    $display("illegal op: rsp_err=%b result=%h zero=%b", rsp_err, rsp_result, rsp_zero);

    // Reset while FULL with last grant to req0; afterwards req0 must win again.
    reset = 1'b1;
    drive(2'b11, 32'd1, 32'd2, ALU_ADD, 32'd3, 32'd4, ALU_ADD, 1'b1);
    @(negedge clk);
    chk("midreset_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("postreset_req_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    chk("postreset_rsp_id", rsp_id, 1'b0);
    chk("postreset_rsp_result", rsp_result, 32'd3);
    $display("reset while full: rsp_id=%0d result=%h", rsp_id, rsp_result);

    // Random traffic against a queue model of the output slot.
    reset = 1'b1;
    drive(2'b00, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      logic [2:0]  legal [5];
      logic [31:0] ra [NREQ];
      logic [31:0] rb [NREQ];
      logic [2:0]  ro [NREQ];
      logic [1:0]  vld, e_rdy;
      logic        rdy, can;
      int          m_last, win, idx;
      exp_t        e;
      legal[0] = ALU_AND; legal[1] = ALU_OR; legal[2] = ALU_ADD; legal[3] = ALU_SUB; legal[4] = ALU_SLT;
      m_last = NREQ - 1;
      q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
        vld = 2'($urandom);
        for (int r = 0; r < NREQ; r++) begin
          ro[r] = legal[$urandom_range(0, 4)];
          ra[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          rb[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        end
        rdy = ($urandom_range(0, 3) != 0);
        drive(vld, ra[0], rb[0], ro[0], ra[1], rb[1], ro[1], rdy);
        @(negedge clk);
        can = (q.size() == 0) || rdy;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (win < 0 && vld[idx]) win = idx;
        end
        e_rdy = (can && win >= 0) ? (2'b01 << win) : 2'b00;
        chk("rand_req_ready", req_ready, e_rdy);
        chk("rand_rsp_valid", rsp_valid, q.size() != 0);
        chk("rand_busy", busy, q.size() != 0);
        if (q.size() != 0) begin
          chk("rand_rsp_result", rsp_result, q[0].res);
          chk("rand_rsp_id", rsp_id, q[0].id);
          chk("rand_rsp_zero", rsp_zero, q[0].z);
          chk("rand_rsp_err", rsp_err, 1'b0);
        end
        $display("rand %0d: vld=%b rdy=%b req_ready=%b rsp_valid=%b result=%h id=%0d",
                 cyc, vld, rdy, req_ready, rsp_valid, rsp_result, rsp_id);
        if (rdy && q.size() != 0) void'(q.pop_front());
        if (e_rdy != 2'b00) begin
          e.res = ref_alu(ro[win], ra[win], rb[win]);
          e.id  = win[0];
          e.z   = (e.res == 32'd0);
          q.push_back(e);
          m_last = win;
        end
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
